// File: rtl/bcd_pkg.sv
// Shared types and constants for the time-shared binary-to-BCD converter.
// The top-level build option BCD_LEADING_BLANK_EN lives in bcd_conv_arbiter.sv.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] BCD_BLANK   = 4'hF;
    localparam logic [DIGIT_W-1:0] ADD3_THRESH = 4'd5;

endpackage

// File: rtl/bcd_dabble_core.sv
// Iterative double-dabble datapath: one add-3/shift step per 'step' cycle.
// The step_* outputs are the post-step values, so the caller can capture a result on the final step edge.
module bcd_dabble_core
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load,
    input  logic                        step,
    input  logic [WIDTH-1:0]            operand,
    output logic [DIGITS*DIGIT_W-1:0]   step_digits,
    output logic                        step_ovf
);

    localparam int BCD_W = DIGITS * DIGIT_W;

    logic [BCD_W-1:0] dig_q;
    logic [BCD_W-1:0] dig_adj;
    logic [WIDTH-1:0] opr_q;
    logic             ovf_q;

    always_comb begin
        dig_adj = dig_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (dig_q[d*DIGIT_W +: DIGIT_W] >= ADD3_THRESH) begin
                dig_adj[d*DIGIT_W +: DIGIT_W] = dig_q[d*DIGIT_W +: DIGIT_W] + 4'd3;
            end
        end
    end

    // A bit leaving the top digit is a carry worth 10^DIGITS, so it can only mean overflow.
    assign step_digits = {dig_adj[BCD_W-2:0], opr_q[WIDTH-1]};
    assign step_ovf    = ovf_q | dig_adj[BCD_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_q <= '0;
            opr_q <= '0;
            ovf_q <= 1'b0;
        end else if (load) begin
            dig_q <= '0;
            opr_q <= operand;
            ovf_q <= 1'b0;
        end else if (step) begin
            dig_q <= step_digits;
            opr_q <= {opr_q[WIDTH-2:0], 1'b0};
            ovf_q <= step_ovf;
        end
    end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one double-dabble engine among NREQ requesters with a req/ack handshake.
// Define BCD_LEADING_BLANK_EN to replace leading zero digits with BCD_BLANK (digit 0 always shown).
module bcd_conv_arbiter
    import bcd_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int WIDTH  = 32,
    parameter int DIGITS = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ*WIDTH-1:0]       bin_in,
    output logic [NREQ-1:0]             ack,
    output logic [2:0]                  ack_id,
    output logic [DIGITS*DIGIT_W-1:0]   bcd_out,
    output logic                        ovf,
    output logic                        busy
);

    localparam int BCD_W = DIGITS * DIGIT_W;
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [2:0]       rr;
    logic [2:0]       winner;
    logic             any_req;
    logic             load;
    logic             step;
    logic [WIDTH-1:0] grant_opr;
    logic [BCD_W-1:0] core_digits;
    logic [BCD_W-1:0] result;
    logic             core_ovf;

    // Search starts just above the last winner, so every requester gets a turn.
    always_comb begin
        int  cand;
        logic found;
        cand   = 0;
        found  = 1'b0;
        winner = 3'd0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = (int'(rr) + i) % NREQ;
            if (!found && req[cand]) begin
                winner = 3'(cand);
                found  = 1'b1;
            end
        end
    end

    assign any_req   = |req;
    assign load      = (state == IDLE) && any_req;
    assign step      = (state == SHIFT);
    assign grant_opr = bin_in[int'(winner)*WIDTH +: WIDTH];

    bcd_dabble_core #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .step        (step),
        .operand     (grant_opr),
        .step_digits (core_digits),
        .step_ovf    (core_ovf)
    );

`ifdef BCD_LEADING_BLANK_EN
    function automatic logic [BCD_W-1:0] blank_leading(input logic [BCD_W-1:0] d);
        logic [BCD_W-1:0] r;
        logic             lead;
        r    = d;
        lead = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (lead && (d[k*DIGIT_W +: DIGIT_W] == 4'd0)) begin
                r[k*DIGIT_W +: DIGIT_W] = BCD_BLANK;
            end else begin
                lead = 1'b0;
            end
        end
        return r;
    endfunction

    assign result = blank_leading(core_digits);
`else
    assign result = core_digits;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= 3'd0;
            rr      <= 3'(NREQ - 1);
            ack     <= '0;
            ack_id  <= 3'd0;
            bcd_out <= '0;
            ovf     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        idx   <= winner;
                        rr    <= winner;
                        cnt   <= CNT_W'(WIDTH);
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        bcd_out <= result;
                        ovf     <= core_ovf;
                        ack     <= NREQ'(1) << idx;
                        ack_id  <= idx;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    ack   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Self-checking bench for bcd_conv_arbiter: directed handshake scenarios plus randomized traffic,
// compared every cycle against a transaction-level model that converts with decimal arithmetic.
module tb_bcd_conv_arbiter;

    localparam int NREQ   = 3;
    localparam int WIDTH  = 32;
    localparam int DIGITS = 8;
    localparam int BCD_W  = DIGITS * 4;
    localparam longint DEC_LIMIT = 64'd100000000;

`ifdef BCD_LEADING_BLANK_EN
    localparam logic [BCD_W-1:0] E_ZERO = 32'hFFFFFFF0;
    localparam logic [BCD_W-1:0] E_907  = 32'hFFFFF907;
    localparam logic [BCD_W-1:0] E_555  = 32'hFFFFF555;
    localparam logic [BCD_W-1:0] E_42   = 32'hFFFFFF42;
`else
    localparam logic [BCD_W-1:0] E_ZERO = 32'h00000000;
    localparam logic [BCD_W-1:0] E_907  = 32'h00000907;
    localparam logic [BCD_W-1:0] E_555  = 32'h00000555;
    localparam logic [BCD_W-1:0] E_42   = 32'h00000042;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NREQ-1:0]        req;
    logic [NREQ*WIDTH-1:0]  bin_in;
    logic [NREQ-1:0]        ack;
    logic [2:0]             ack_id;
    logic [BCD_W-1:0]       bcd_out;
    logic                   ovf;
    logic                   busy;

    int n_compared = 0;
    int n_mismatch = 0;

    bcd_conv_arbiter #(
        .NREQ   (NREQ),
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .bin_in  (bin_in),
        .ack     (ack),
        .ack_id  (ack_id),
        .bcd_out (bcd_out),
        .ovf     (ovf),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int k, input logic [WIDTH-1:0] v);
        bin_in[k*WIDTH +: WIDTH] = v;
        req[k] = 1'b1;
    endtask

    // Decimal conversion by repeated division; blanking applied to the digit string afterwards.
    function automatic logic [BCD_W-1:0] model_digits(input logic [WIDTH-1:0] v);
        longint           r;
        logic [BCD_W-1:0] d;
        logic             lead;
        r = longint'(v) % DEC_LIMIT;
        d = '0;
        for (int k = 0; k < DIGITS; k++) begin
            d[k*4 +: 4] = 4'(r % 10);
            r = r / 10;
        end
`ifdef BCD_LEADING_BLANK_EN
        lead = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (lead && d[k*4 +: 4] == 4'd0) d[k*4 +: 4] = 4'hF;
            else lead = 1'b0;
        end
`else
        lead = 1'b0;
`endif
        return d;
    endfunction

    // Transaction model: a grant, WIDTH busy cycles, then one ack cycle.
    logic [NREQ-1:0]  exp_ack = '0;
    logic [2:0]       exp_ack_id = 3'd0;
    logic [BCD_W-1:0] exp_bcd = '0;
    logic             exp_ovf = 1'b0;
    logic             exp_busy = 1'b0;
    int               m_rr = NREQ - 1;
    int               m_id = 0;
    int               m_remain = 0;
    logic             m_done = 1'b0;
    logic [WIDTH-1:0] m_opr = '0;

    always @(posedge clk or negedge rst_n) begin : model
        int w;
        int c;
        if (!rst_n) begin
            exp_ack    <= '0;
            exp_ack_id <= 3'd0;
            exp_bcd    <= '0;
            exp_ovf    <= 1'b0;
            exp_busy   <= 1'b0;
            m_rr       <= NREQ - 1;
            m_remain   <= 0;
            m_done     <= 1'b0;
        end else if (m_done) begin
            exp_ack  <= '0;
            exp_busy <= 1'b0;
            m_done   <= 1'b0;
        end else if (m_remain > 0) begin
            m_remain <= m_remain - 1;
            if (m_remain == 1) begin
                exp_ack    <= NREQ'(1) << m_id;
                exp_ack_id <= 3'(m_id);
                exp_bcd    <= model_digits(m_opr);
                exp_ovf    <= (longint'(m_opr) >= DEC_LIMIT);
                m_done     <= 1'b1;
            end
        end else if (req != '0) begin
            w = -1;
            for (int i = 1; i <= NREQ; i++) begin
                c = (m_rr + i) % NREQ;
                if (w < 0 && req[c]) w = c;
            end
            m_id     <= w;
            m_rr     <= w;
            m_opr    <= bin_in[w*WIDTH +: WIDTH];
            m_remain <= WIDTH;
            exp_busy <= 1'b1;
        end
    end

    always @(negedge clk) begin
        checkOutput("cyc_ack", 64'(ack), 64'(exp_ack));
        checkOutput("cyc_busy", 64'(busy), 64'(exp_busy));
        checkOutput("cyc_bcd_out", 64'(bcd_out), 64'(exp_bcd));
        checkOutput("cyc_ovf", 64'(ovf), 64'(exp_ovf));
        if (exp_ack != '0) checkOutput("cyc_ack_id", 64'(ack_id), 64'(exp_ack_id));
    end

    task automatic wait_ack(input int k, input int limit, output int cycles);
        cycles = 0;
        while (1) begin
            @(negedge clk);
            cycles++;
            if (ack[k]) break;
            if (cycles >= limit) begin
                n_compared++;
                n_mismatch++;
                $display("[TB] FAIL ack_timeout: requester %0d got no ack in %0d cycles, expected one", k, limit);
                break;
            end
        end
    endtask

    function automatic logic [WIDTH-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return $urandom();
            2:       return $urandom_range(0, 99999999);
            3:       return 32'd99999999 + $urandom_range(0, 2);
            default: return $urandom_range(0, 9999);
        endcase
    endfunction

    initial begin
        int cyc;
        int got_id[4];
        int got_t[4];
        int n_acks;
        int t;
        logic rearm;
        int wait_cnt[NREQ];

        rst_n  = 1'b1;
        req    = '0;
        bin_in = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_ack", 64'(ack), 64'd0);
        checkOutput("reset_ack_id", 64'(ack_id), 64'd0);
        checkOutput("reset_bcd_out", 64'(bcd_out), 64'd0);
        checkOutput("reset_ovf", 64'(ovf), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(0, 32'd12345678);
        wait_ack(0, 40, cyc);
        checkOutput("single_latency", 64'(cyc), 64'(WIDTH + 1));
        checkOutput("single_ack_id", 64'(ack_id), 64'd0);
        checkOutput("single_bcd", 64'(bcd_out), 64'h12345678);
        checkOutput("single_ovf", 64'(ovf), 64'd0);
        req[0] = 1'b0;
        @(negedge clk);
        checkOutput("single_busy_after", 64'(busy), 64'd0);
        checkOutput("single_ack_after", 64'(ack), 64'd0);

        applyStimulus(1, 32'd0);
        wait_ack(1, 40, cyc);
        checkOutput("zero_bcd", 64'(bcd_out), 64'(E_ZERO));
        checkOutput("zero_ack_id", 64'(ack_id), 64'd1);
        req[1] = 1'b0;
        @(negedge clk);
        applyStimulus(1, 32'd907);
        wait_ack(1, 40, cyc);
        checkOutput("d907_bcd", 64'(bcd_out), 64'(E_907));
        req[1] = 1'b0;
        @(negedge clk);

        applyStimulus(2, 32'hFFFFFFFF);
        wait_ack(2, 40, cyc);
        checkOutput("max_ovf", 64'(ovf), 64'd1);
        checkOutput("max_bcd", 64'(bcd_out), 64'h94967295);
        checkOutput("max_ack_id", 64'(ack_id), 64'd2);
        req[2] = 1'b0;
        @(negedge clk);
        applyStimulus(2, 32'd99999999);
        wait_ack(2, 40, cyc);
        checkOutput("nines_ovf", 64'(ovf), 64'd0);
        checkOutput("nines_bcd", 64'(bcd_out), 64'h99999999);
        req[2] = 1'b0;
        @(negedge clk);

        // Contention: all requesters pending straight out of reset.
        #2 rst_n = 1'b0;
        applyStimulus(0, 32'd11);
        applyStimulus(1, 32'd22);
        applyStimulus(2, 32'd33);
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            got_id[i] = -1;
            got_t[i]  = 0;
        end
        n_acks = 0;
        t = 0;
        rearm = 1'b0;
        while (n_acks < 4 && t < 200) begin
            @(negedge clk);
            t++;
            if (rearm) begin
                applyStimulus(0, 32'd44);
                rearm = 1'b0;
            end
            if (ack != '0) begin
                for (int k = 0; k < NREQ; k++) if (ack[k]) got_id[n_acks] = k;
                got_t[n_acks] = t;
                req[got_id[n_acks]] = 1'b0;
                if (n_acks == 0) rearm = 1'b1;
                n_acks++;
            end
        end
        checkOutput("cont_order0", 64'(got_id[0]), 64'd0);
        checkOutput("cont_order1", 64'(got_id[1]), 64'd1);
        checkOutput("cont_order2", 64'(got_id[2]), 64'd2);
        checkOutput("cont_order3", 64'(got_id[3]), 64'd0);
        for (int i = 0; i < 3; i++)
            checkOutput("cont_spacing", 64'(got_t[i+1] - got_t[i]), 64'(WIDTH + 2));
        @(negedge clk);

        // Reset in the middle of a conversion discards it.
        applyStimulus(0, 32'd555);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rstmid_ack", 64'(ack), 64'd0);
        checkOutput("rstmid_busy", 64'(busy), 64'd0);
        checkOutput("rstmid_bcd", 64'(bcd_out), 64'd0);
        checkOutput("rstmid_ovf", 64'(ovf), 64'd0);
        checkOutput("rstmid_ack_id", 64'(ack_id), 64'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        wait_ack(0, 40, cyc);
        checkOutput("rstmid_relatency", 64'(cyc), 64'(WIDTH + 1));
        checkOutput("rstmid_bcd_after", 64'(bcd_out), 64'(E_555));
        req[0] = 1'b0;
        @(negedge clk);

        // Requester 0 walks away mid-conversion while requester 1 waits.
        applyStimulus(0, 32'd42);
        repeat (5) @(negedge clk);
        req[0] = 1'b0;
        applyStimulus(1, 32'd7);
        wait_ack(0, 40, cyc);
        checkOutput("aband_bcd", 64'(bcd_out), 64'(E_42));
        checkOutput("aband_ack_id", 64'(ack_id), 64'd0);
        wait_ack(1, 40, cyc);
        checkOutput("aband_next_latency", 64'(cyc), 64'(WIDTH + 2));
        checkOutput("aband_next_id", 64'(ack_id), 64'd1);
        req[1] = 1'b0;
        @(negedge clk);

        for (int k = 0; k < NREQ; k++) wait_cnt[k] = 0;
        for (int c = 0; c < 3200; c++) begin
            @(negedge clk);
            for (int k = 0; k < NREQ; k++) begin
                if (req[k] && ack[k]) begin
                    req[k] = 1'b0;
                    wait_cnt[k] = 0;
                end else if (req[k]) begin
                    wait_cnt[k]++;
                    if (wait_cnt[k] > 150) begin
                        n_compared++;
                        n_mismatch++;
                        $display("[TB] FAIL rand_ack_timeout: requester %0d waited %0d cycles, expected at most 150", k, wait_cnt[k]);
                        req[k] = 1'b0;
                        wait_cnt[k] = 0;
                    end
                end else if (c < 3000 && $urandom_range(0, 7) == 0) begin
                    applyStimulus(k, rand_operand());
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule

// File: doc/bcd_conv_arbiter.md
Name: bcd_conv_arbiter

Overview:
- Shares one iterative double-dabble binary-to-BCD engine among NREQ requesters, e.g. score, high score and timer feeding the 7-segment/VGA digit display.
- Round-robin arbitration and a req/ack handshake per requester.
- Sequences the engine over WIDTH shift cycles.
- Returns packed BCD digits plus an overflow flag.

Parameters:
- NREQ, 3, number of requesters (2..8)
- WIDTH, 32, binary operand width
- DIGITS, 8, BCD digits produced (output width DIGITS*4)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester request level
- bin_in  in  NREQ*WIDTH  operands; requester k at bits [k*WIDTH +: WIDTH]
- ack  out  NREQ  one-hot, one-cycle done pulse
- ack_id  out  3  index of the requester being acked; valid while any ack bit is high
- bcd_out  out  DIGITS*4  packed BCD result, digit 0 in bits [3:0]
- ovf  out  1  result not representable in DIGITS digits
- busy  out  1  high in SHIFT and DONE

Behaviour:
- Reset values (asynchronous, immediate):
  - state=IDLE, ack=0, ack_id=0, bcd_out=0, ovf=0, busy=0
  - rr pointer = NREQ-1, so requester 0 has first priority
  - engine digits and counter cleared
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with any req bit high, select the winner: the first set bit searching from rr+1 upward with wrap.
  - Capture the winner's bin_in into the operand shift register; clear the digit registers and the overflow sticky bit.
  - Load cnt=WIDTH, store the winner index, set rr to the winner, go to SHIFT.
  - With no request, stay in IDLE.
- SHIFT, per edge:
  - Every digit >=5 gets +3 first.
  - Then shift the whole {digits, operand} chain left by 1.
  - The bit shifted out of the top digit's bit 3 ORs into the overflow sticky.
  - Decrement cnt. On the edge where cnt goes 1->0: load bcd_out and ovf from the post-shift values and go to DONE.
- DONE (exactly one cycle):
  - ack[idx]=1 and ack_id=idx.
  - Next edge returns to IDLE. req is not sampled in DONE.
- Latency: ack is high in the cycle following the WIDTH-th edge after the sampling edge.
  - Throughput: one conversion per WIDTH+2 cycles.
- Handshake:
  - The requester holds req and bin_in stable until it sees ack.
  - It deasserts req at the edge ending the ack cycle.
  - A req still high in IDLE after that edge is treated as a new request.
- bin_in is sampled only at grant; later changes are ignored.
- bcd_out and ovf hold their values until the next DONE load.
- A req dropped mid-conversion does not abort. The conversion completes and ack still pulses.
- Overflow:
  - ovf=1 exactly when the operand >= 10^DIGITS.
  - bcd_out then holds the low DIGITS decimal digits.
- Arithmetic is unsigned. An all-zero operand gives all-zero digits.
- Reset asserted mid-SHIFT or mid-DONE: immediate return to IDLE with no ack, and the pending result is discarded.

Optional Feature:
- Macro: BCD_LEADING_BLANK_EN.
- With the macro defined:
  - At the DONE load, every leading zero digit above the most significant nonzero digit becomes 4'hF (display blank).
  - Digit 0 is never blanked, so a zero result shows as a single "0".
- Without it: raw BCD, leading zeros kept.
- ovf behaviour is identical in both builds.

Decomposition:
- Package bcd_pkg holds:
  - state enum {IDLE, SHIFT, DONE}
  - BCD_BLANK = 4'hF
  - DIGIT_W = 4
  - the add-3 threshold constant 5
- One sub-module, bcd_dabble_core:
  - Inputs: load, step, operand.
  - Outputs: post-step digit vector and overflow sticky.
  - Purely the shift/adjust datapath.
- The arbiter owns the FSM, cnt, rr pointer, handshake and output registers.

Test Plan:
- Single request: req[0] with bin_in[0]=12345678 from IDLE → ack[0] high 32 edges after the sample edge, ack_id=0, bcd_out=32'h12345678, ovf=0, busy low one cycle later.
- Zero operand: req[1] with bin_in[1]=0 → bcd_out=32'h00000000.
  - With BCD_LEADING_BLANK_EN: bcd_out=32'hFFFFFFF0.
  - Also req[1] with 907 under blanking → bcd_out=32'hFFFFF907.
- Overflow: req[2] with bin_in[2]=32'hFFFFFFFF (4294967295) → ovf=1, bcd_out=32'h94967295.
  - Then req[2] with 99999999 → ovf=0, bcd_out=32'h99999999.
- Contention: all three req held high from reset, each dropped on its own ack → ack order 0,1,2, then requester 0 re-armed wins next. Ack pulses are spaced 34 cycles apart.
- Reset mid-conversion: assert rst_n=0 at SHIFT cycle 10 of a conversion of 555 → all outputs 0 immediately and no ack. After release, re-request 555 → bcd_out=32'h00000555.
- Abandoned request: drop req[0] at cycle 5 of SHIFT with operand 42 → ack[0] still pulses and bcd_out=32'h00000042. Next grant goes to a pending req[1], not req[0].
